cache_bus_requester: RTL
========================

Name: cache_bus_requester

Overview:
- Cache-side bus master. Sits between one cache (instruction or data) and the shared memory bus.
- On a cache miss it raises its bid to the bus arbiter and waits for that client's grant. It then issues a line-aligned read to the memory controller and collects BEATS data beats. It returns the assembled line to the cache.
- It releases the bus only after the arbiter has withdrawn the grant.
- One instance per cache: the instruction cache drives arbiter bid/grant pair 1, the data cache drives pair 2.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus data beat width.
- BEATS, 8, beats per cache line; power of 2, at least 2. Line = BEATS*DATA_W bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  cache miss request.
- req_addr  in  ADDR_W  miss address (byte address).
- req_ready  out  1  requester can accept a miss.
- resp_valid  out  1  one-cycle pulse: line fill complete.
- resp_line  out  BEATS*DATA_W  assembled line; beat i occupies bits [i*DATA_W +: DATA_W].
- bus_bid  out  1  bid to the arbiter.
- bus_grant  in  1  grant from the arbiter (registered, lags bid by 2 cycles).
- bus_addr_valid  out  1  read command valid to the memory controller.
- bus_addr  out  ADDR_W  line-aligned read address.
- bus_addr_ready  in  1  memory controller accepts the command.
- bus_rdata_valid  in  1  read beat valid.
- bus_rdata  in  DATA_W  read beat data, returned in ascending beat order.

Behaviour:
- All outputs are registered.
- Reset (reset==0, asynchronous): state=IDLE; req_ready=1; resp_valid=0; resp_line=0; bus_bid=0; bus_addr_valid=0; bus_addr=0; beat counter=0.
  - bus_bid drops immediately on reset assertion, mid-operation included. Partial line data is discarded.
- States: IDLE, BID, ADDR, FILL, DONE, RELEASE.
- IDLE: req_ready=1.
  - On req_valid: latch bus_addr = req_addr with the low log2(BEATS*DATA_W/8) bits cleared.
  - Next cycle: req_ready=0, bus_bid=1, state goes to BID.
- BID: hold bus_bid=1. When bus_grant==1, go to ADDR with bus_addr_valid=1.
  - No timeout. The requester waits indefinitely.
- ADDR: hold bus_addr_valid and bus_addr stable until bus_addr_ready==1.
  - On that cycle the command is accepted: bus_addr_valid=0 next cycle, beat counter=0, state goes to FILL.
- FILL: each cycle with bus_rdata_valid==1, store bus_rdata into slot[counter] and increment the counter.
  - Beats may arrive with gaps.
  - The beat taken when counter==BEATS-1 moves the state to DONE. The counter wraps to 0.
  - bus_grant is not checked in FILL.
- DONE: resp_valid=1 for exactly one cycle; resp_line is valid on that cycle and held until the next fill overwrites it.
  - bus_bid=0 from this cycle on. State goes to RELEASE.
- RELEASE: bus_bid=0. Stay until bus_grant==0 is sampled, then go to IDLE with req_ready=1.
  - This stops a stale, lagging grant from being taken as a new grant.
- Ignored inputs:
  - bus_rdata_valid outside FILL.
  - bus_addr_ready outside ADDR.
  - req_valid outside IDLE (req_ready=0 there).
- Back-to-back misses: the minimum time from resp_valid to the next bus_bid is set by the grant falling. With the standard arbiter this is 2 cycles after the bid drops, then 1 cycle in IDLE.
- Simultaneous events:
  - In ADDR, bus_addr_ready and bus_rdata_valid may be high on the same cycle. That rdata is ignored; beats count only from FILL onward.
  - The memory controller must not return data before the command is accepted.

Test Plan:
- Single miss: req_addr=0x1234, grant 2 cycles after bid, addr_ready immediately, 8 consecutive beats 0xA0..0xA7 -> bus_addr=0x1200; resp_valid pulses once; resp_line[63:0]=0xA0 and resp_line[511:448]=0xA7; bus_bid low on the resp_valid cycle.
- Gapped beats and addr stall: bus_addr_ready held low 5 cycles, then beats with 1-cycle gaps -> bus_addr_valid and bus_addr stable for all 5 stall cycles; resp_valid only after the 8th beat; line order correct.
- Stale grant: bus_grant stays high 2 cycles after bus_bid drops; req_valid held high throughout -> req_ready stays 0 until grant==0 is seen; the new bid starts the cycle after IDLE; no ADDR until a fresh grant rises.
- Grant contention: bus_grant held low 20 cycles during BID -> bus_bid stays 1, bus_addr_valid stays 0, no state advance; normal fill once grant rises.
- Reset mid-FILL after 3 beats -> bus_bid, bus_addr_valid and resp_valid go 0 immediately (asynchronously); req_ready=1 after reset release; the next miss fills a complete, correct line with no beats left over from before reset.
- Spurious inputs: bus_rdata_valid pulses in IDLE and BID, bus_addr_ready pulses in IDLE -> no state change, no resp_valid, resp_line unchanged.

Source files
------------

// File: rtl/cache_bus_requester.sv
// Cache-side bus master: bids for the shared bus on a miss, issues one
// line-aligned read, collects BEATS data beats and returns the assembled line.
module cache_bus_requester #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic [ADDR_W-1:0]         req_addr,
    output logic                      req_ready,
    output logic                      resp_valid,
    output logic [BEATS*DATA_W-1:0]   resp_line,
    output logic                      bus_bid,
    input  logic                      bus_grant,
    output logic                      bus_addr_valid,
    output logic [ADDR_W-1:0]         bus_addr,
    input  logic                      bus_addr_ready,
    input  logic                      bus_rdata_valid,
    input  logic [DATA_W-1:0]         bus_rdata
);

    localparam int unsigned LINE_W = BEATS * DATA_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(0) << OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BID,
        S_ADDR,
        S_FILL,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [LINE_W-1:0]   resp_line_q, resp_line_d;
    logic                bus_bid_q, bus_bid_d;
    logic                bus_addr_valid_q, bus_addr_valid_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d          = state_q;
        req_ready_d      = req_ready_q;
        resp_valid_d     = 1'b0;
        resp_line_d      = resp_line_q;
        bus_bid_d        = bus_bid_q;
        bus_addr_valid_d = bus_addr_valid_q;
        bus_addr_d       = bus_addr_q;
        cnt_d            = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    bus_addr_d  = req_addr & LINE_MASK;
                    req_ready_d = 1'b0;
                    bus_bid_d   = 1'b1;
                    state_d     = S_BID;
                end
            end
            S_BID: begin
                if (bus_grant) begin
                    bus_addr_valid_d = 1'b1;
                    state_d          = S_ADDR;
                end
            end
            S_ADDR: begin
                // rdata on the accept cycle is deliberately dropped
                if (bus_addr_ready) begin
                    bus_addr_valid_d = 1'b0;
                    cnt_d            = '0;
                    state_d          = S_FILL;
                end
            end
            S_FILL: begin
                if (bus_rdata_valid) begin
                    for (int unsigned i = 0; i < BEATS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            resp_line_d[i*DATA_W +: DATA_W] = bus_rdata;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        resp_valid_d = 1'b1;
                        bus_bid_d    = 1'b0;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Wait out the lagging grant so it is never mistaken for a new one
                if (!bus_grant) begin
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d          = S_IDLE;
                req_ready_d      = 1'b1;
                bus_bid_d        = 1'b0;
                bus_addr_valid_d = 1'b0;
                cnt_d            = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_line_q      <= '0;
            bus_bid_q        <= 1'b0;
            bus_addr_valid_q <= 1'b0;
            bus_addr_q       <= '0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_line_q      <= resp_line_d;
            bus_bid_q        <= bus_bid_d;
            bus_addr_valid_q <= bus_addr_valid_d;
            bus_addr_q       <= bus_addr_d;
            cnt_q            <= cnt_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_line      = resp_line_q;
    assign bus_bid        = bus_bid_q;
    assign bus_addr_valid = bus_addr_valid_q;
    assign bus_addr       = bus_addr_q;

endmodule
